// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - Instruction fetch stage: PC, imem address and IF/ID register
module fetch_stage #(
    parameter int unsigned          ADDR_W    = 12,
    parameter int unsigned          INSTR_W   = 19,
    parameter logic [ADDR_W-1:0]    RESET_PC  = '0,
    parameter logic [INSTR_W-1:0]   NOP_INSTR = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                redirect,
    input  logic [ADDR_W-1:0]   redirect_pc,
    input  logic                halt,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic [INSTR_W-1:0]  imem_data,
    output logic [INSTR_W-1:0]  if_id_instr,
    output logic [ADDR_W-1:0]   if_id_pc1,
    output logic                if_id_valid,
    output logic                halted,
    output logic [15:0]         fetch_count
);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t               state, state_next;
    logic [ADDR_W-1:0]    pc, pc_next;
    logic [ADDR_W-1:0]    pc_inc;
    logic [INSTR_W-1:0]   instr_next;
    logic [ADDR_W-1:0]    pc1_next;
    logic                 valid_next;
    logic [15:0]          count_next;

    assign pc_inc    = pc + ADDR_W'(1);
    assign imem_addr = pc;
    assign halted    = (state == HALTED);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            pc          <= RESET_PC;
            if_id_instr <= NOP_INSTR;
            if_id_pc1   <= '0;
            if_id_valid <= 1'b0;
            fetch_count <= '0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            if_id_instr <= instr_next;
            if_id_pc1   <= pc1_next;
            if_id_valid <= valid_next;
            fetch_count <= count_next;
        end
    end

    // Redirect outranks halt and stall: it comes from an older instruction,
    // so a pending HALT or hazard belongs to the squashed path.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        instr_next = if_id_instr;
        pc1_next   = if_id_pc1;
        valid_next = if_id_valid;
        count_next = fetch_count;

        if (redirect) begin
            state_next = RUN;
            pc_next    = redirect_pc;
            instr_next = NOP_INSTR;
            pc1_next   = '0;
            valid_next = 1'b0;
        end else if (state == HALTED) begin
            instr_next = NOP_INSTR;
            valid_next = 1'b0;
        end else if (stall) begin
            // Hold everything; the HALT word must stay in IF/ID until the stall clears.
        end else if (halt) begin
            state_next = HALTED;
            instr_next = NOP_INSTR;
            valid_next = 1'b0;
        end else begin
            pc_next    = pc_inc;
            instr_next = imem_data;
            pc1_next   = pc_inc;
            valid_next = 1'b1;
            if (fetch_count != 16'hFFFF) begin
                count_next = fetch_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - Directed self-checking bench for fetch_stage
module tb_fetch_stage;

    localparam int unsigned ADDR_W  = 12;
    localparam int unsigned INSTR_W = 19;

    logic               clk = 1'b0;
    logic               rst;
    logic               stall;
    logic               redirect;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               halt;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_data;
    logic [INSTR_W-1:0] if_id_instr;
    logic [ADDR_W-1:0]  if_id_pc1;
    logic               if_id_valid;
    logic               halted;
    logic [15:0]        fetch_count;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // imem[k] = k + 100
    assign imem_data = INSTR_W'(imem_addr) + 19'd100;

    fetch_stage #(
        .ADDR_W    (ADDR_W),
        .INSTR_W   (INSTR_W),
        .RESET_PC  (12'h000),
        .NOP_INSTR (19'h00000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .if_id_instr (if_id_instr),
        .if_id_pc1   (if_id_pc1),
        .if_id_valid (if_id_valid),
        .halted      (halted),
        .fetch_count (fetch_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; halt = 1'b0;
        step();
        step();
        chk("rst_addr",  32'(imem_addr),   32'h0);
        chk("rst_valid", 32'(if_id_valid), 32'h0);
        chk("rst_instr", 32'(if_id_instr), 32'h0);
        chk("rst_pc1",   32'(if_id_pc1),   32'h0);
        chk("rst_halted", 32'(halted),     32'h0);
        chk("rst_count", 32'(fetch_count), 32'h0);

        rst = 1'b0;
        step();
        chk("run1_addr",  32'(imem_addr),   32'd1);
        chk("run1_instr", 32'(if_id_instr), 32'd100);
        chk("run1_pc1",   32'(if_id_pc1),   32'd1);
        chk("run1_valid", 32'(if_id_valid), 32'd1);
        step();
        chk("run2_addr",  32'(imem_addr),   32'd2);
        chk("run2_instr", 32'(if_id_instr), 32'd101);
        chk("run2_pc1",   32'(if_id_pc1),   32'd2);
        step();
        chk("run3_addr",  32'(imem_addr),   32'd3);
        chk("run3_instr", 32'(if_id_instr), 32'd102);
        chk("run3_pc1",   32'(if_id_pc1),   32'd3);
        chk("run3_count", 32'(fetch_count), 32'd3);

        step();
        step();
        chk("pre_stall_addr", 32'(imem_addr), 32'd5);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_addr",  32'(imem_addr),   32'd5);
            chk("stall_instr", 32'(if_id_instr), 32'd104);
            chk("stall_count", 32'(fetch_count), 32'd5);
        end
        stall = 1'b0;
        step();
        chk("unstall_addr",  32'(imem_addr),   32'd6);
        chk("unstall_instr", 32'(if_id_instr), 32'd105);
        chk("unstall_pc1",   32'(if_id_pc1),   32'd6);
        chk("unstall_count", 32'(fetch_count), 32'd6);

        step();
        step();
        chk("pre_redir_addr", 32'(imem_addr), 32'd8);
        redirect = 1'b1; redirect_pc = 12'h040; stall = 1'b1;
        step();
        chk("redir_addr",  32'(imem_addr),   32'h40);
        chk("redir_valid", 32'(if_id_valid), 32'd0);
        chk("redir_instr", 32'(if_id_instr), 32'd0);
        chk("redir_count", 32'(fetch_count), 32'd8);
        redirect = 1'b0; stall = 1'b0;
        step();
        chk("post_redir_instr", 32'(if_id_instr), 32'h40 + 32'd100);
        chk("post_redir_pc1",   32'(if_id_pc1),   32'h41);
        chk("post_redir_count", 32'(fetch_count), 32'd9);

        redirect = 1'b1; redirect_pc = 12'd20;
        step();
        redirect = 1'b0;
        chk("pre_halt_addr", 32'(imem_addr), 32'd20);
        halt = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("halt_halted", 32'(halted),      32'd1);
            chk("halt_addr",   32'(imem_addr),   32'd20);
            chk("halt_valid",  32'(if_id_valid), 32'd0);
            chk("halt_count",  32'(fetch_count), 32'd9);
        end
        halt = 1'b0;
        redirect = 1'b1; redirect_pc = 12'h010;
        step();
        redirect = 1'b0;
        chk("unhalt_halted", 32'(halted),    32'd0);
        chk("unhalt_addr",   32'(imem_addr), 32'h10);
        step();
        chk("resume_instr", 32'(if_id_instr), 32'h10 + 32'd100);
        chk("resume_pc1",   32'(if_id_pc1),   32'h11);
        chk("resume_count", 32'(fetch_count), 32'd10);

        halt = 1'b1; stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("hstall_halted", 32'(halted),      32'd0);
            chk("hstall_instr",  32'(if_id_instr), 32'h10 + 32'd100);
            chk("hstall_addr",   32'(imem_addr),   32'h11);
        end
        stall = 1'b0;
        step();
        chk("hstall_rel_halted", 32'(halted),      32'd1);
        chk("hstall_rel_valid",  32'(if_id_valid), 32'd0);
        chk("hstall_rel_count",  32'(fetch_count), 32'd10);

        halt = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_addr",   32'(imem_addr),   32'd0);
        chk("midrst_halted", 32'(halted),      32'd0);
        chk("midrst_count",  32'(fetch_count), 32'd0);

        redirect = 1'b1; redirect_pc = 12'hFFF;
        step();
        redirect = 1'b0;
        chk("wrap_pre_addr", 32'(imem_addr), 32'hFFF);
        step();
        chk("wrap_addr",  32'(imem_addr),   32'h000);
        chk("wrap_pc1",   32'(if_id_pc1),   32'h000);
        chk("wrap_instr", 32'(if_id_instr), 32'hFFF + 32'd100);
        chk("wrap_count", 32'(fetch_count), 32'd1);

        repeat (65534) step();
        chk("sat_reach", 32'(fetch_count), 32'hFFFF);
        step();
        chk("sat_hold",  32'(fetch_count), 32'hFFFF);
        chk("sat_valid", 32'(if_id_valid), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
